// File: rtl/mult_div_unit_32.sv
// rtl/mult_div_unit_32.sv - multi-cycle signed multiply/divide unit with HI/LO result registers
// Radix-2 shift-add multiply and restoring divide on magnitudes, one bit per cycle.
module mult_div_unit_32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [3:0] OP_MULT = 4'b1000;
    localparam logic [3:0] OP_DIV  = 4'b1001;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_res_q, neg_res_d;
    logic                 neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]     a_mag_q, a_mag_d;
    logic [WIDTH-1:0]     b_mag_q, b_mag_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH:0]       rem_q, rem_d;
    logic                 dbz_q, dbz_d;
    logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;

    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   mul_next, prod_fin;
    logic [WIDTH+1:0]     shifted, diff;
    logic                 qbit;
    logic [WIDTH-1:0]     quo_next, rem_next;
    logic                 accept;

    // Multiply: low half of acc holds the multiplier and shifts out as product bits arrive.
    // Divide: low half of acc holds the dividend and shifts in quotient bits.
    always_comb begin
        sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, a_mag_q & {WIDTH{acc_q[0]}}};
        mul_next = {sum, acc_q[WIDTH-1:1]};
        prod_fin = neg_res_q ? (~mul_next + 1'b1) : mul_next;
        shifted  = {rem_q, acc_q[WIDTH-1]};
        diff     = shifted - {2'b00, b_mag_q};
        qbit     = ~diff[WIDTH+1];
        quo_next = {acc_q[WIDTH-2:0], qbit};
        rem_next = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

    assign accept = start && ((alu_control == OP_MULT) || (alu_control == OP_DIV));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        a_mag_d   = a_mag_q;
        b_mag_d   = b_mag_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        dbz_d     = dbz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    is_div_d  = (alu_control == OP_DIV);
                    neg_res_d = operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
                    neg_rem_d = operand_a[WIDTH-1];
                    a_mag_d   = operand_a[WIDTH-1] ? (~operand_a + 1'b1) : operand_a;
                    b_mag_d   = operand_b[WIDTH-1] ? (~operand_b + 1'b1) : operand_b;
                    cnt_d     = '0;
                    dbz_d     = 1'b0;
                    rem_d     = '0;
                    if (alu_control == OP_DIV) begin
                        acc_d = {{WIDTH{1'b0}}, a_mag_d};
                    end else begin
                        acc_d = {{WIDTH{1'b0}}, b_mag_d};
                    end
                    state_d = CALC;
                    if ((alu_control == OP_DIV) && (operand_b == '0)) begin
                        hi_d    = operand_a;
                        lo_d    = '1;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            CALC: begin
                cnt_d = cnt_q + 1'b1;
                if (is_div_q) begin
                    acc_d = {acc_q[2*WIDTH-1:WIDTH], quo_next};
                    rem_d = {1'b0, rem_next};
                end else begin
                    acc_d = mul_next;
                end
                if (cnt_q == CW'(WIDTH-1)) begin
                    state_d = DONE;
                    if (is_div_q) begin
                        lo_d = neg_res_q ? (~quo_next + 1'b1) : quo_next;
                        hi_d = neg_rem_q ? (~rem_next + 1'b1) : rem_next;
                    end else begin
                        hi_d = prod_fin[2*WIDTH-1:WIDTH];
                        lo_d = prod_fin[WIDTH-1:0];
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            a_mag_q   <= '0;
            b_mag_q   <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            dbz_q     <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            a_mag_q   <= a_mag_d;
            b_mag_q   <= b_mag_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            dbz_q     <= dbz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
endmodule

// File: tb/tb_mult_div_unit_32.sv
// tb/tb_mult_div_unit_32.sv - directed self-checking bench for mult_div_unit_32
module tb_mult_div_unit_32;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  alu_control = 4'b0000;
    logic [31:0] operand_a = '0;
    logic [31:0] operand_b = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    mult_div_unit_32 #(.WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .alu_control(alu_control),
        .operand_a(operand_a), .operand_b(operand_b), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Drives one start at a negedge; returns cycles until done seen (100 = timeout).
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] code,
                          output int lat);
        @(negedge clk);
        start = 1'b1; alu_control = code; operand_a = a; operand_b = b;
        @(negedge clk);
        start = 1'b0; operand_a = 32'hDEADBEEF; operand_b = 32'h12345678; alu_control = 4'b0000;
        lat = 1;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    int lat, seen, bcnt;
    logic [31:0] hold_hi, hold_lo;

    initial begin
        #1;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_hi_lo", {hi, lo}, 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        run_op(32'hFFFFFFFD, 32'd7, 4'b1000, lat);
        check("mul_m3x7_lat", lat, 33);
        check("mul_m3x7_busy", {63'd0, busy}, 64'd1);
        check("mul_m3x7", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);

        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 4'b1000, lat);
        check("mul_m1xm1", {hi, lo}, 64'h00000000_00000001);

        run_op(32'h7FFFFFFF, 32'h7FFFFFFF, 4'b1000, lat);
        check("mul_max", {hi, lo}, 64'h3FFFFFFF_00000001);

        // Reset in the middle of a multiply
        @(negedge clk);
        start = 1'b1; alu_control = 4'b1000; operand_a = 32'd9; operand_b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrst_busy_done", {62'd0, busy, done}, 64'd0);
        check("midrst_hi_lo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        check("midrst_no_done", seen, 0);

        run_op(32'hFFFFFFF9, 32'd2, 4'b1001, lat);
        check("div_m7d2_lat", lat, 33);
        check("div_m7d2", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
        check("div_m7d2_dbz", {63'd0, div_by_zero}, 64'd0);

        run_op(32'd7, 32'hFFFFFFFE, 4'b1001, lat);
        check("div_7dm2", {hi, lo}, 64'h00000001_FFFFFFFD);

        run_op(32'h80000000, 32'hFFFFFFFF, 4'b1001, lat);
        check("div_ovf", {hi, lo}, 64'h00000000_80000000);
        check("div_ovf_dbz", {63'd0, div_by_zero}, 64'd0);

        run_op(32'd100, 32'd0, 4'b1001, lat);
        check("dbz_lat", lat, 1);
        check("dbz_res", {hi, lo}, 64'h00000064_FFFFFFFF);
        check("dbz_flag", {63'd0, div_by_zero}, 64'd1);
        @(negedge clk);
        check("dbz_sticky", {63'd0, div_by_zero}, 64'd1);

        // Next accepted start clears the flag at acceptance
        @(negedge clk);
        start = 1'b1; alu_control = 4'b1000; operand_a = 32'd1000; operand_b = 32'hFFFFFC18;
        @(negedge clk);
        check("dbz_clear", {63'd0, div_by_zero}, 64'd0);
        // Hammer start with other operands through CALC and DONE
        operand_a = 32'd5; operand_b = 32'd5;
        lat = 1;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
            operand_a = operand_a + 1;
        end
        check("proto_lat", lat, 33);
        check("proto_first_only", {hi, lo}, 64'hFFFFFFFF_FFF0BDC0);
        start = 1'b0;
        run_op(32'd3, 32'd4, 4'b1000, lat);
        check("proto_b2b_lat", lat, 33);
        check("proto_b2b_res", {hi, lo}, 64'h00000000_0000000C);

        // Foreign opcode is ignored
        @(negedge clk);
        hold_hi = hi; hold_lo = lo;
        start = 1'b1; alu_control = 4'b0010; operand_a = 32'd77; operand_b = 32'd0;
        bcnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (busy) bcnt++;
        end
        start = 1'b0;
        check("nop_busy", bcnt, 0);
        check("nop_hold", {hi, lo}, {hold_hi, hold_lo});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
